// File: rtl/mario_physics_engine.sv
// mario_physics_engine
//   Per physics tick: scans 8 collision probes around Mario through one shared
//   map-ROM read port, then applies walking, the jump/fall state machine,
//   death detection and coin-bump scoring in a single UPDATE cycle.
// Ports:
//   clk_i, rst_i (sync, active high), tick_i (step strobe)
//   jump_i/left_i/right_i, view_x_i : controls, sampled on an accepted tick
//   map_addr_o -> ROM, map_data_i <- ROM (valid ROM_LAT cycles later)
//   mario_x_o, mario_y_o, facing_o, vstate_o, death_o, score_o : player state
//   busy_o (scan running), done_o (1-cycle, outputs fresh), tick_drop_o (sticky)
module mario_physics_engine #(
  parameter int TILE_LG2 = 6,
  parameter int MAP_COLS = 212,
  parameter int MAP_ROWS = 14,
  parameter int X_W = 11,
  parameter int Y_W = 10,
  parameter int VIEW_W = 16,
  parameter int ADDR_W = 12,
  parameter int ID_W = 6,
  parameter int SCORE_W = 32,
  parameter int INIT_X = 128,
  parameter int INIT_Y = 704,
  parameter int X_MAX = 640,
  parameter int WALK_STEP = 16,
  parameter int JUMP_STEP = 32,
  parameter int FALL_STEP = 32,
  parameter int JUMP_TICKS = 10,
  parameter int DEATH_Y = 832,
  parameter int ROM_LAT = 1,
  parameter logic [(1<<ID_W)-1:0] SOLID_MASK = 64'h0000_00C0_0000_200F,
  parameter logic [(1<<ID_W)-1:0] PLATFORM_MASK = '0,
  parameter int COIN_ID = 0,
  parameter int COIN_POINTS = 100
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               jump_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic [VIEW_W-1:0]  view_x_i,
  output logic [ADDR_W-1:0]  map_addr_o,
  input  logic [ID_W-1:0]    map_data_i,
  output logic [X_W-1:0]     mario_x_o,
  output logic [Y_W-1:0]     mario_y_o,
  output logic               facing_o,
  output logic [1:0]         vstate_o,
  output logic               death_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               tick_drop_o
);
  localparam int T    = 1 << TILE_LG2;
  localparam int PW   = ((VIEW_W > X_W) ? VIEW_W : X_W) + 2;  // room for sum + sign
  localparam int QW   = Y_W + 2;
  localparam int RW   = $clog2(JUMP_TICKS + 1);
  localparam int CW   = 4;
  localparam int LAST = 7 + ROM_LAT;  // cycle index where probe 7 data arrives

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_UPDATE} seq_t;
  typedef enum logic [1:0] {V_GND = 2'b00, V_RISE = 2'b01, V_FALL = 2'b10, V_DEAD = 2'b11} vst_t;

  seq_t seq_q, seq_d;
  vst_t vs_q, vs_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [RW-1:0]      rise_q, rise_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               facing_q, facing_d, death_q, death_d, tick_drop_q;
  logic               j_q, l_q, r_q;
  logic [VIEW_W-1:0]  vx_q;
  logic [7:0]         neg_q, oob_q, blk_q, blk_all;
  logic [1:0]         coin_q, coin_all;

  // Probe order: 0 UP_L, 1 UP_R, 2 DN_L, 3 DN_R, 4 LF_T, 5 LF_B, 6 RT_T, 7 RT_B
  function automatic logic [PW-1:0] dx_of(input logic [2:0] k);
    case (k)
      3'd1, 3'd3: dx_of = PW'(T - 1);
      3'd4, 3'd5: dx_of = '1;
      3'd6, 3'd7: dx_of = PW'(T);
      default:    dx_of = '0;
    endcase
  endfunction

  function automatic logic [QW-1:0] dy_of(input logic [2:0] k);
    case (k)
      3'd0, 3'd1: dy_of = '1;
      3'd2, 3'd3: dy_of = QW'(T);
      3'd5, 3'd7: dy_of = QW'(T - 1);
      default:    dy_of = '0;
    endcase
  endfunction

  // ---- probe address generation (ISSUE) ----
  logic [2:0]    k;
  logic [PW-1:0] px;
  logic [QW-1:0] py;
  logic          p_neg, p_oob, issue;

  assign k     = cyc_q[2:0];
  assign issue = (seq_q == S_ISSUE);

  always_comb begin
    px    = PW'(vx_q) + PW'(x_q) + dx_of(k);
    py    = QW'(y_q) + dy_of(k);
    p_neg = px[PW-1] | py[QW-1];
    p_oob = !p_neg && (32'(py >> TILE_LG2) >= 32'(MAP_ROWS));
    map_addr_o = '0;
    // negative probes still occupy their ROM slot, just at address 0
    if (issue && !p_neg)
      map_addr_o = ADDR_W'(32'(py >> TILE_LG2) * 32'(MAP_COLS) + 32'(px >> TILE_LG2));
  end

  // ---- data capture: probe ci returns ROM_LAT cycles after issue ----
  logic                  cap, blk_now, coin_now;
  logic [2:0]            ci;
  logic [(1<<ID_W)-1:0]  blk_mask;

  assign ci  = 3'(cyc_q - CW'(ROM_LAT));
  assign cap = (seq_q == S_ISSUE || seq_q == S_DRAIN) &&
               cyc_q >= CW'(ROM_LAT) && cyc_q <= CW'(LAST);

  always_comb begin
    // downward probes also land on one-way platforms
    blk_mask = (ci == 3'd2 || ci == 3'd3) ? (SOLID_MASK | PLATFORM_MASK) : SOLID_MASK;
    blk_now  = neg_q[ci] | (!oob_q[ci] && blk_mask[map_data_i]);
    coin_now = !neg_q[ci] && !oob_q[ci] && (map_data_i == ID_W'(COIN_ID));
    blk_all  = blk_q;
    coin_all = coin_q;
    // forward the live sample so the final probe is usable in the same cycle
    if (cap) begin
      blk_all[ci] = blk_now;
      if (ci < 3'd2) coin_all[ci[0]] = coin_now;
    end
  end

  // ---- physics next state ----
  logic ceil, grd, wall_l, wall_r, coin_hit;
  logic [X_W:0]     x_r;
  logic [SCORE_W:0] s_sum;

  always_comb begin
    ceil     = blk_all[0] | blk_all[1];
    grd      = blk_all[2] | blk_all[3];
    wall_l   = blk_all[4] | blk_all[5];
    wall_r   = blk_all[6] | blk_all[7];
    coin_hit = coin_all[0] | coin_all[1];
    x_r      = {1'b0, x_q} + (X_W+1)'(WALK_STEP);
    s_sum    = {1'b0, score_q} + (SCORE_W+1)'(COIN_POINTS);
    x_d = x_q; y_d = y_q; vs_d = vs_q; rise_d = rise_q;
    facing_d = facing_q; death_d = death_q; score_d = score_q;
    if (vs_q != V_DEAD) begin
      if (r_q && !l_q) begin
        facing_d = 1'b0;
        if (!wall_r) x_d = (x_r > (X_W+1)'(X_MAX)) ? X_W'(X_MAX) : x_r[X_W-1:0];
      end else if (l_q && !r_q) begin
        facing_d = 1'b1;
        if (!wall_l) x_d = (x_q < X_W'(WALK_STEP)) ? '0 : x_q - X_W'(WALK_STEP);
      end
      case (vs_q)
        V_GND: begin
          if (j_q) begin
            vs_d   = V_RISE;
            rise_d = '0;
          end else if (!grd) vs_d = V_FALL;
        end
        V_RISE: begin
          if (ceil || rise_q == RW'(JUMP_TICKS) || y_q < Y_W'(JUMP_STEP)) begin
            vs_d = V_FALL;
            if (ceil && coin_hit)
              score_d = s_sum[SCORE_W] ? '1 : s_sum[SCORE_W-1:0];
          end else begin
            y_d    = y_q - Y_W'(JUMP_STEP);
            rise_d = rise_q + RW'(1);
          end
        end
        default: begin  // V_FALL
          if (grd) begin
            vs_d = V_GND;
            y_d  = y_q & ~Y_W'(T - 1);
          end else y_d = y_q + Y_W'(FALL_STEP);
        end
      endcase
      if (y_d >= Y_W'(DEATH_Y)) begin
        vs_d    = V_DEAD;
        death_d = 1'b1;
      end
    end
  end

  // ---- sequencer ----
  logic accept, upd;
  assign accept = tick_i && (seq_q == S_IDLE || seq_q == S_UPDATE);
  assign upd    = (seq_q == S_DRAIN) && (cyc_q == CW'(LAST));

  always_comb begin
    seq_d = seq_q;
    cyc_d = cyc_q;
    case (seq_q)
      S_ISSUE: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == CW'(7)) seq_d = S_DRAIN;
      end
      S_DRAIN: begin
        cyc_d = cyc_q + CW'(1);
        if (upd) seq_d = S_UPDATE;
      end
      default: begin  // S_IDLE, S_UPDATE
        seq_d = accept ? S_ISSUE : S_IDLE;
        cyc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q <= S_IDLE;  cyc_q <= '0;
      x_q <= X_W'(INIT_X);  y_q <= Y_W'(INIT_Y);
      vs_q <= V_GND;  rise_q <= '0;  score_q <= '0;
      facing_q <= 1'b0;  death_q <= 1'b0;  tick_drop_q <= 1'b0;
      j_q <= 1'b0;  l_q <= 1'b0;  r_q <= 1'b0;  vx_q <= '0;
      neg_q <= '0;  oob_q <= '0;  blk_q <= '0;  coin_q <= '0;
    end else begin
      seq_q <= seq_d;
      cyc_q <= cyc_d;
      if (tick_i && busy_o) tick_drop_q <= 1'b1;
      if (accept) begin
        j_q <= jump_i;  l_q <= left_i;  r_q <= right_i;  vx_q <= view_x_i;
      end
      if (issue) begin
        neg_q[k] <= p_neg;
        oob_q[k] <= p_oob;
      end
      if (cap) begin
        blk_q  <= blk_all;
        coin_q <= coin_all;
      end
      if (upd) begin
        x_q <= x_d;  y_q <= y_d;  vs_q <= vs_d;  rise_q <= rise_d;
        score_q <= score_d;  facing_q <= facing_d;  death_q <= death_d;
      end
    end
  end

  assign mario_x_o   = x_q;
  assign mario_y_o   = y_q;
  assign facing_o    = facing_q;
  assign vstate_o    = vs_q;
  assign death_o     = death_q;
  assign score_o     = score_q;
  assign busy_o      = (seq_q == S_ISSUE) || (seq_q == S_DRAIN);
  assign done_o      = (seq_q == S_UPDATE);
  assign tick_drop_o = tick_drop_q;
endmodule
